// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, status-register bit positions and defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Bit positions in the status register; the transmitter will use TXI/TBNF.
  localparam int FE   = 7;
  localparam int PE   = 6;
  localparam int OR   = 5;
  localparam int NF   = 4;
  localparam int TXI  = 3;
  localparam int TBNF = 2;
  localparam int DR   = 1;
  localparam int ENA  = 0;

  localparam int OSR_DEFAULT = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Circular-buffer FIFO with wrap-around pointers, occupancy count and synchronous flush.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampled 8-bit UART receiver: majority-voted bit sampling, optional even parity,
// per-frame error pulses and a small receive FIFO popped by bus reads.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OSR   = OSR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       baud_tick,
  input  logic       rxd,
  input  logic       parity_en,
  input  logic       rd,
  output logic [7:0] rdata,
  output logic [7:0] status_int
);

  localparam int TW = $clog2(OSR);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [TW-1:0] SMP_A = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] SMP_B = TW'(OSR / 2);
  localparam logic [TW-1:0] SMP_C = TW'(OSR / 2 + 1);
  localparam logic [TW-1:0] LAST  = TW'(OSR - 1);

  rx_state_t     state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic          rxd_m;
  logic          rxd_s;
  logic          smp0;
  logic          smp1;
  logic          par_q;
  logic          noise_q;
  logic          perr_q;
  logic [7:0]    shreg;
  logic          fe_q;
  logic          pe_q;
  logic          or_q;
  logic          nf_q;

  logic          maj;
  logic          split;
  logic          done;
  logic          push_req;
  logic          pop_ok;
  logic          fe_p;
  logic          pe_p;
  logic          or_p;
  logic          nf_p;

  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // The third sample is the live synchronised value, so the vote resolves on that tick.
  assign maj   = maj3(smp0, smp1, rxd_s);
  assign split = (smp0 != smp1) || (smp1 != rxd_s);

  assign done     = ena && baud_tick && (state == STOP) && (tick_cnt == SMP_C);
  assign push_req = done && maj;
  assign pop_ok   = ena && rd && !empty;

  assign fe_p = done && !maj;
  assign pe_p = push_req && perr_q;
  assign or_p = push_req && full && !pop_ok;
  assign nf_p = done && (noise_q || split);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      smp0     <= 1'b1;
      smp1     <= 1'b1;
      par_q    <= 1'b0;
      noise_q  <= 1'b0;
      perr_q   <= 1'b0;
      shreg    <= '0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
      or_q     <= 1'b0;
      nf_q     <= 1'b0;
    end else if (!ena) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
      or_q     <= 1'b0;
      nf_q     <= 1'b0;
    end else begin
      fe_q <= fe_p;
      pe_q <= pe_p;
      or_q <= or_p;
      nf_q <= nf_p;
      if (baud_tick) begin
        if (state == IDLE) begin
          if (!rxd_s) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            noise_q  <= 1'b0;
            perr_q   <= 1'b0;
            par_q    <= parity_en;
          end
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
          if (tick_cnt == SMP_A) smp0 <= rxd_s;
          if (tick_cnt == SMP_B) smp1 <= rxd_s;
          if (tick_cnt == SMP_C) noise_q <= noise_q | split;
          case (state)
            START: begin
              if (tick_cnt == SMP_C && maj) begin
                state <= IDLE;
              end else if (tick_cnt == LAST) begin
                state    <= DATA;
                tick_cnt <= '0;
              end
            end
            DATA: begin
              if (tick_cnt == SMP_C) shreg <= {maj, shreg[7:1]};
              if (tick_cnt == LAST) begin
                tick_cnt <= '0;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state <= par_q ? PARITY : STOP;
              end
            end
            PARITY: begin
              if (tick_cnt == SMP_C) perr_q <= maj ^ (^shreg);
              if (tick_cnt == LAST) begin
                state    <= STOP;
                tick_cnt <= '0;
              end
            end
            STOP: begin
              // Leave at mid-stop so a following start edge is never missed.
              if (tick_cnt == SMP_C) begin
                state    <= IDLE;
                tick_cnt <= '0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  rx_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (!ena),
    .push  (push_req),
    .pop   (pop_ok),
    .wdata (shreg),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    status_int = '0;
    if (ena) begin
      status_int[FE] = fe_q;
      status_int[PE] = pe_q;
      status_int[OR] = or_q;
      status_int[NF] = nf_q;
      status_int[DR] = (count != '0);
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed and randomized frames against a queue-based receive model for uart_rx_frontend.
`timescale 1ns/1ps
module tb_uart_rx_frontend;

  localparam int DEPTH = 4;
  localparam int OSR   = 16;
  localparam int TDIV  = 4;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       ena       = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rxd       = 1'b1;
  logic       parity_en = 1'b0;
  logic       rd        = 1'b0;
  logic [7:0] rdata;
  logic [7:0] status_int;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int fe_n = 0, pe_n = 0, or_n = 0, nf_n = 0, wide_n = 0, rsv_n = 0;
  logic [7:0] prev_st = 8'h00;
  int div = 0;

  uart_rx_frontend #(.DEPTH(DEPTH), .OSR(OSR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .baud_tick  (baud_tick),
    .rxd        (rxd),
    .parity_en  (parity_en),
    .rd         (rd),
    .rdata      (rdata),
    .status_int (status_int)
  );

  // clock / baud strobe
  always #50 clk = ~clk;
  always @(negedge clk) begin
    div = (div + 1) % TDIV;
    baud_tick = (div == 0);
  end

  // pulse monitor: counts pulse cycles, flags pulses wider than one clk and reserved bits
  always @(negedge clk) begin
    if (status_int[7]) fe_n++;
    if (status_int[6]) pe_n++;
    if (status_int[5]) or_n++;
    if (status_int[4]) nf_n++;
    if ((status_int & prev_st & 8'hF0) != 8'h00) wide_n++;
    if ((status_int & 8'h0D) != 8'h00) rsv_n++;
    prev_st = status_int;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_edge();
    do @(posedge clk); while (baud_tick !== 1'b1);
  endtask

  task automatic drive_bit(input logic v, input int nz_off, input int rd_off);
    for (int off = 0; off < OSR; off++) begin
      tick_edge();
      #1;
      rd  = 1'b0;
      rxd = (off == nz_off) ? ~v : v;
      if (off == rd_off) begin
        repeat (TDIV - 1) @(posedge clk);
        #1 rd = 1'b1;
      end
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_edge();
      #1;
      rd  = 1'b0;
      rxd = 1'b1;
    end
  endtask

  task automatic check_head(input string tag);
    check({tag, " dr"}, status_int[1], exp_q.size() != 0);
    check({tag, " rdata"}, rdata, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
  endtask

  task automatic check_pulses(input string tag, input int fe0, input int pe0, input int or0,
                              input int nf0, input bit efe, input bit epe, input bit eor,
                              input bit enf);
    check({tag, " fe"}, fe_n - fe0, efe);
    check({tag, " pe"}, pe_n - pe0, epe);
    check({tag, " or"}, or_n - or0, eor);
    check({tag, " nf"}, nf_n - nf0, enf);
  endtask

  // nz_bit: frame bit index (0=start) with one inverted sample at offset nz_off.
  // rd_mid: bus read lands on the mid-stop decision clk.
  task automatic send_frame(input string tag, input logic [7:0] d, input bit par, input bit pbad,
                            input bit stop_v, input int nz_bit, input int nz_off, input bit rd_mid);
    int fe0, pe0, or0, nf0, nb;
    logic v, pbit;
    bit eor;
    fe0 = fe_n; pe0 = pe_n; or0 = or_n; nf0 = nf_n;
    pbit = (^d) ^ pbad;
    nb = par ? 11 : 10;
    parity_en = par;
    for (int j = 0; j < nb; j++) begin
      if (j == 0) v = 1'b0;
      else if (j <= 8) v = d[j-1];
      else if (par && j == 9) v = pbit;
      else v = stop_v;
      if (j == 2) parity_en = ~par;
      drive_bit(v, (j == nz_bit) ? nz_off : -1, (j == nb - 1 && rd_mid) ? OSR / 2 + 2 : -1);
    end
    idle_ticks(stop_v ? 2 : 12);
    eor = 1'b0;
    if (rd_mid && exp_q.size() != 0) void'(exp_q.pop_front());
    if (stop_v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else eor = 1'b1;
    end
    check_pulses(tag, fe0, pe0, or0, nf0, !stop_v, stop_v && par && pbad, eor, nz_bit >= 0);
    check_head(tag);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    parity_en = 1'b0;
    drive_bit(1'b0, -1, -1);
    for (int j = 0; j < nbits; j++) drive_bit(d[j], -1, -1);
  endtask

  task automatic bus_read(input string tag);
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check_head(tag);
  endtask

  initial begin
    int fe0, pe0, or0, nf0, nb;
    logic [7:0] d;
    bit par, pbad, stop_v, rdm;
    int nz, nzo;

    // reset state
    repeat (5) @(posedge clk);
    #1;
    check("reset status", status_int, 8'h00);
    check("reset rdata", rdata, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 ena = 1'b1;
    idle_ticks(4);
    check("enabled status", status_int, 8'h00);

    // clean 8N1, parity error, framing error, noisy sample
    send_frame("a5", 8'hA5, 0, 0, 1, -1, 0, 0);
    bus_read("a5 rd");
    send_frame("par03", 8'h03, 1, 1, 1, -1, 0, 0);
    bus_read("par03 rd");
    send_frame("fe55", 8'h55, 0, 0, 0, -1, 0, 0);
    send_frame("nz00", 8'h00, 0, 0, 1, 3, OSR / 2 + 2, 0);
    bus_read("nz00 rd");

    // overflow, then pop+push on a full FIFO
    for (int i = 1; i <= 5; i++) send_frame($sformatf("fill%0d", i), 8'(i), 0, 0, 1, -1, 0, 0);
    send_frame("full rdpush", 8'h06, 0, 0, 1, -1, 0, 1);
    for (int i = 0; i < 4; i++) bus_read($sformatf("drain%0d", i));
    bus_read("rd empty");

    // short low glitch on idle line
    fe0 = fe_n; pe0 = pe_n; or0 = or_n; nf0 = nf_n;
    @(posedge clk); #1 rxd = 1'b0;
    #2000 rxd = 1'b1;
    idle_ticks(40);
    check_pulses("glitch", fe0, pe0, or0, nf0, 0, 0, 0, 0);
    check_head("glitch");
    send_frame("post glitch", 8'h3C, 0, 0, 1, -1, 0, 0);
    bus_read("post glitch rd");

    // randomized frames
    for (int i = 0; i < 14; i++) begin
      d      = 8'($urandom);
      par    = 1'($urandom_range(0, 1));
      pbad   = ($urandom_range(0, 3) == 0);
      stop_v = ($urandom_range(0, 5) != 0);
      rdm    = ($urandom_range(0, 3) == 0);
      nb     = par ? 11 : 10;
      nz     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
      nzo    = $urandom_range(OSR / 2, OSR / 2 + 2);
      send_frame($sformatf("rnd%0d", i), d, par, pbad, stop_v, nz, nzo, rdm);
      if ($urandom_range(0, 2) == 0) bus_read($sformatf("rnd%0d rd", i));
    end

    // ena dropped mid-frame
    send_frame("pre ena", 8'h81, 0, 0, 1, -1, 0, 0);
    fe0 = fe_n; pe0 = pe_n; or0 = or_n; nf0 = nf_n;
    send_partial(8'h7E, 3);
    #1 ena = 1'b0;
    #1 check("ena off status", status_int, 8'h00);
    @(posedge clk); #1;
    check("ena off rdata", rdata, 8'h00);
    rxd = 1'b1;
    idle_ticks(20);
    ena = 1'b1;
    exp_q.delete();
    idle_ticks(40);
    check_pulses("ena abort", fe0, pe0, or0, nf0, 0, 0, 0, 0);
    check_head("ena abort");

    // reset mid-DATA
    send_frame("pre rst", 8'h42, 0, 0, 1, -1, 0, 0);
    send_partial(8'h99, 4);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid status", status_int, 8'h00);
    check("rst mid rdata", rdata, 8'h00);
    rxd = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    idle_ticks(4);
    send_frame("post rst", 8'hE7, 0, 0, 1, -1, 0, 0);
    bus_read("post rst rd");

    check("pulse width", wide_n, 0);
    check("reserved bits", rsv_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
